// File: rtl/bullet_pool.sv
// Per-tank bullet pool: allocates slots on fire with a cooldown, moves and
// reflects live bullets once per frame, and retires them on kill, expiry or exit.
module bullet_pool #(
   parameter int NUM_BULLETS = 3,
   parameter int LIFE_FRAMES = 240,
   parameter int COOLDOWN    = 15,
   parameter int SPEED       = 4,
   parameter int SCREEN_W    = 640,
   parameter int SCREEN_H    = 480
) (
   input  logic                        frame_clk,
   input  logic                        Reset,
   input  logic                        fire,
   input  logic [9:0]                  tankX,
   input  logic [9:0]                  tankY,
   input  logic signed [7:0]           sin,
   input  logic signed [7:0]           cos,
   input  logic [NUM_BULLETS-1:0]      wall_top,
   input  logic [NUM_BULLETS-1:0]      wall_bottom,
   input  logic [NUM_BULLETS-1:0]      wall_left,
   input  logic [NUM_BULLETS-1:0]      wall_right,
   input  logic [NUM_BULLETS-1:0]      kill,
   output logic                        fire_ack,
   output logic [NUM_BULLETS-1:0]      is_bullet_active,
   output logic [10*NUM_BULLETS-1:0]   BulletX,
   output logic [10*NUM_BULLETS-1:0]   BulletY,
   output logic [3:0]                  active_count
);

   localparam int CD_W = (COOLDOWN < 1) ? 1 : $clog2(COOLDOWN + 1);

   logic [NUM_BULLETS-1:0] active_r;
   logic [9:0]             x_r    [NUM_BULLETS];
   logic [9:0]             y_r    [NUM_BULLETS];
   logic signed [9:0]      vx_r   [NUM_BULLETS];
   logic signed [9:0]      vy_r   [NUM_BULLETS];
   logic [8:0]             life_r [NUM_BULLETS];
   logic [CD_W-1:0]        cooldown_r;

   logic [NUM_BULLETS-1:0] free;
   logic [NUM_BULLETS-1:0] grant;
   logic                   fire_acc;
   logic signed [9:0]      spawn_vx;
   logic signed [9:0]      spawn_vy;

   logic signed [9:0]      vx_ref  [NUM_BULLETS];
   logic signed [9:0]      vy_ref  [NUM_BULLETS];
   logic signed [10:0]     nx      [NUM_BULLETS];
   logic signed [10:0]     ny      [NUM_BULLETS];
   logic [NUM_BULLETS-1:0] off_scr;

   // Rounded fixed-point scaling of a Q1.7 heading component by SPEED.
   function automatic logic signed [9:0] spawn_vel(input logic signed [7:0] trig);
      int prod;
      prod = (SPEED * int'(trig) + 64) >>> 7;
      return prod[9:0];
   endfunction

   assign free     = ~active_r;
   assign grant    = free & (-free);
   assign fire_acc = fire && (cooldown_r == '0) && (|free);
   assign spawn_vx = spawn_vel(cos);
   assign spawn_vy = spawn_vel(sin);

   always_comb begin
      for (int i = 0; i < NUM_BULLETS; i++) begin
         vx_ref[i]  = (wall_left[i] || wall_right[i])  ? -vx_r[i] : vx_r[i];
         vy_ref[i]  = (wall_top[i]  || wall_bottom[i]) ? -vy_r[i] : vy_r[i];
         nx[i]      = $signed({1'b0, x_r[i]}) + $signed({vx_ref[i][9], vx_ref[i]});
         ny[i]      = $signed({1'b0, y_r[i]}) + $signed({vy_ref[i][9], vy_ref[i]});
         off_scr[i] = nx[i][10] || ny[i][10] ||
                      (int'(nx[i]) > SCREEN_W - 1) || (int'(ny[i]) > SCREEN_H - 1);
      end
   end

   // Frame-edge state update: spawn has priority over kill/expiry/move.
   always_ff @(posedge frame_clk or posedge Reset) begin
      if (Reset) begin
         active_r   <= '0;
         cooldown_r <= '0;
         fire_ack   <= 1'b0;
         for (int i = 0; i < NUM_BULLETS; i++) begin
            x_r[i]    <= '0;
            y_r[i]    <= '0;
            vx_r[i]   <= '0;
            vy_r[i]   <= '0;
            life_r[i] <= '0;
         end
      end else begin
         fire_ack <= fire_acc;
         if (fire_acc)
            cooldown_r <= CD_W'(COOLDOWN);
         else if (cooldown_r != '0)
            cooldown_r <= cooldown_r - 1'b1;

         for (int i = 0; i < NUM_BULLETS; i++) begin
            if (fire_acc && grant[i]) begin
               active_r[i] <= 1'b1;
               x_r[i]      <= tankX;
               y_r[i]      <= tankY;
               vx_r[i]     <= spawn_vx;
               vy_r[i]     <= spawn_vy;
               life_r[i]   <= 9'(LIFE_FRAMES);
            end else if (active_r[i]) begin
               if (kill[i]) begin
                  active_r[i] <= 1'b0;
               end else if (life_r[i] == 9'd1) begin
                  active_r[i] <= 1'b0;
               end else begin
                  vx_r[i]   <= vx_ref[i];
                  vy_r[i]   <= vy_ref[i];
                  life_r[i] <= life_r[i] - 1'b1;
                  if (off_scr[i]) begin
                     active_r[i] <= 1'b0;
                  end else begin
                     x_r[i] <= nx[i][9:0];
                     y_r[i] <= ny[i][9:0];
                  end
               end
            end
         end
      end
   end

   always_comb begin
      active_count     = '0;
      is_bullet_active = active_r;
      BulletX          = '0;
      BulletY          = '0;
      for (int i = 0; i < NUM_BULLETS; i++) begin
         active_count         = active_count + 4'(active_r[i]);
         BulletX[10*i +: 10]  = x_r[i];
         BulletY[10*i +: 10]  = y_r[i];
      end
   end

endmodule

// File: tb/tb_bullet_pool.sv
// Directed bench for bullet_pool with default parameters (3 slots, cooldown 15, life 240).
module tb_bullet_pool;

   logic        frame_clk;
   logic        Reset;
   logic        fire;
   logic [9:0]  tankX, tankY;
   logic signed [7:0] sin, cos;
   logic [2:0]  wall_top, wall_bottom, wall_left, wall_right, kill;
   logic        fire_ack;
   logic [2:0]  is_bullet_active;
   logic [29:0] BulletX, BulletY;
   logic [3:0]  active_count;

   int n_cmp = 0;
   int n_err = 0;

   bullet_pool dut (
      .frame_clk        (frame_clk),
      .Reset            (Reset),
      .fire             (fire),
      .tankX            (tankX),
      .tankY            (tankY),
      .sin              (sin),
      .cos              (cos),
      .wall_top         (wall_top),
      .wall_bottom      (wall_bottom),
      .wall_left        (wall_left),
      .wall_right       (wall_right),
      .kill             (kill),
      .fire_ack         (fire_ack),
      .is_bullet_active (is_bullet_active),
      .BulletX          (BulletX),
      .BulletY          (BulletY),
      .active_count     (active_count)
   );

   initial frame_clk = 1'b0;
   always #5 frame_clk = ~frame_clk;

   task automatic chk(input string tag, input int obs, input int exp);
      n_cmp++;
      if (obs != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int bx(input int i);
      return int'(BulletX[10*i +: 10]);
   endfunction

   function automatic int by(input int i);
      return int'(BulletY[10*i +: 10]);
   endfunction

   task automatic tick();
      @(posedge frame_clk);
      #1;
   endtask

   task automatic pulse_reset();
      Reset = 1'b1;
      #1;
      Reset = 1'b0;
   endtask

   initial begin
      Reset = 1'b1; fire = 1'b0; tankX = '0; tankY = '0; sin = '0; cos = '0;
      wall_top = '0; wall_bottom = '0; wall_left = '0; wall_right = '0; kill = '0;
      #12;
      chk("rst_ack",    fire_ack, 0);
      chk("rst_active", is_bullet_active, 0);
      chk("rst_count",  active_count, 0);
      chk("rst_x",      int'(BulletX), 0);
      chk("rst_y",      int'(BulletY), 0);
      Reset = 1'b0;

      // single shot, rightward
      tankX = 320; tankY = 240; cos = 127; sin = 0; fire = 1'b1;
      tick();
      chk("t1_ack",    fire_ack, 1);
      chk("t1_active", is_bullet_active, 3'b001);
      chk("t1_x0",     bx(0), 320);
      chk("t1_y0",     by(0), 240);
      fire = 1'b0;
      tick();
      chk("t1_ack2",   fire_ack, 0);
      chk("t1_x1",     bx(0), 324);
      tick();
      chk("t1_x2",     bx(0), 328);
      chk("t1_y2",     by(0), 240);
      chk("t1_count",  active_count, 1);

      // held fire with cooldown, slots fill in order
      pulse_reset();
      fire = 1'b1;
      for (int k = 0; k < 40; k++) begin
         tick();
         chk($sformatf("t2_ack_e%0d", k), fire_ack, (k == 0 || k == 16 || k == 32) ? 1 : 0);
      end
      chk("t2_active", is_bullet_active, 3'b111);
      chk("t2_x0", bx(0), 476);
      chk("t2_x1", bx(1), 412);
      chk("t2_x2", bx(2), 348);

      // pool full after cooldown expiry: request dropped
      fire = 1'b0;
      repeat (8) tick();
      fire = 1'b1;
      tick();
      chk("t3_full_ack",    fire_ack, 0);
      chk("t3_full_active", is_bullet_active, 3'b111);
      chk("t3_x0",          bx(0), 512);
      chk("t3_x1",          bx(1), 448);
      chk("t3_x2",          bx(2), 384);
      kill = 3'b010;
      tick();
      chk("t3_kill_ack",    fire_ack, 0);
      chk("t3_kill_active", is_bullet_active, 3'b101);
      kill = 3'b000; tankX = 200; tankY = 100;
      tick();
      chk("t3_reuse_ack",    fire_ack, 1);
      chk("t3_reuse_active", is_bullet_active, 3'b111);
      chk("t3_reuse_x1",     bx(1), 200);
      chk("t3_reuse_y1",     by(1), 100);
      chk("t3_x0_moves",     bx(0), 520);
      fire = 1'b0;

      // corner reflection
      pulse_reset();
      tankX = 100; tankY = 100; cos = 127; sin = -128; fire = 1'b1;
      tick();
      chk("t4_spawn_x", bx(0), 100);
      fire = 1'b0; wall_top = 3'b001; wall_left = 3'b001;
      tick();
      chk("t4_refl_x", bx(0), 96);
      chk("t4_refl_y", by(0), 104);
      wall_top = '0; wall_left = '0;
      tick();
      chk("t4_after_x", bx(0), 92);
      chk("t4_after_y", by(0), 108);

      // lifetime expiry of a stationary bullet
      pulse_reset();
      tankX = 50; tankY = 50; cos = 0; sin = 0; fire = 1'b1;
      tick();
      chk("t5_spawn", is_bullet_active, 3'b001);
      fire = 1'b0;
      for (int k = 1; k <= 240; k++) begin
         tick();
         if (k == 239) chk("t5_live_e239", is_bullet_active, 3'b001);
         if (k == 240) begin
            chk("t5_dead_e240", is_bullet_active, 3'b000);
            chk("t5_count",     active_count, 0);
            chk("t5_x_held",    bx(0), 50);
         end
      end

      // leaving the right edge
      pulse_reset();
      tankX = 638; tankY = 10; cos = 127; sin = 0; fire = 1'b1;
      tick();
      chk("t6_spawn", bx(0), 638);
      fire = 1'b0;
      tick();
      chk("t6_exit_active", is_bullet_active, 3'b000);
      chk("t6_exit_x_held", bx(0), 638);

      // asynchronous reset mid-flight
      pulse_reset();
      tankX = 320; tankY = 240; fire = 1'b1;
      tick();
      chk("t7_pre_ack", fire_ack, 1);
      Reset = 1'b1;
      #1;
      chk("t7_ack",    fire_ack, 0);
      chk("t7_active", is_bullet_active, 0);
      chk("t7_count",  active_count, 0);
      chk("t7_x",      int'(BulletX), 0);
      chk("t7_y",      int'(BulletY), 0);
      Reset = 1'b0;
      tick();
      chk("t7_first_fire", fire_ack, 1);
      chk("t7_first_x",    bx(0), 320);
      fire = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
